// File: rtl/pll_reset_pkg.sv
// pll_reset_pkg: shared types and constants for the PLL reset sequencer.
//   seq_state_e          - sequencer FSM states
//   *_DEF                - default parameter values for the sequencer
//   LOSS_CNT_MAX         - saturation value of the lock-loss counter
package pll_reset_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  localparam int SYNC_STAGES_DEF        = 2;
  localparam int LOCK_STABLE_CYCLES_DEF = 1024;
  localparam int STAGE_GAP_DEF          = 16;
  localparam int NUM_STAGES_DEF         = 3;

  localparam logic [7:0] LOSS_CNT_MAX = 8'hFF;

endpackage

// File: rtl/pll_reset_sequencer_sync_bit.sv
// sync_bit: STAGES-deep flip-flop synchroniser for one asynchronous bit.
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low clear (chain clears to 0)
//   d_i    - asynchronous input
//   q_o    - synchronised output (last flop of the chain)
module sync_bit
  import pll_reset_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: qualifies PLL lock stability, then releases NUM_STAGES
// active-high resets one at a time (bit 0 first). Lock loss or an external
// reset request re-asserts every stage at once.
//   clock           - domain clock (one PLL output)
//   resetn          - asynchronous active-low reset
//   pll_locked      - PLL lock, asynchronous to clock
//   ext_reset_req   - active-high reset request, asynchronous
//   reset_out       - per-stage resets, bit i released after bit i-1
//   ready           - high once every stage is released
//   lock_loss_count - saturating count of lock-loss aborts
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int SYNC_STAGES        = SYNC_STAGES_DEF,
  parameter int LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEF,
  parameter int STAGE_GAP          = STAGE_GAP_DEF,
  parameter int NUM_STAGES         = NUM_STAGES_DEF
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  pll_locked,
  input  logic                  ext_reset_req,
  output logic [NUM_STAGES-1:0] reset_out,
  output logic                  ready,
  output logic [7:0]            lock_loss_count
);

  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > STAGE_GAP) ? LOCK_STABLE_CYCLES : STAGE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STAGE_GAP - 1);
  localparam logic [3:0]       STAGE_LAST = 4'(NUM_STAGES - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == LOSS_CNT_MAX) ? v : v + 8'd1;
  endfunction

  logic lock_s;
  logic req_s;

  seq_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]            stage_q, stage_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic                  ready_q, ready_d;
  logic [7:0]            loss_q, loss_d;
  logic                  abort;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk_i  (clock),
    .rst_ni (resetn),
    .d_i    (pll_locked),
    .q_o    (lock_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_req (
    .clk_i  (clock),
    .rst_ni (resetn),
    .d_i    (ext_reset_req),
    .q_o    (req_s)
  );

  assign abort = !lock_s || req_s;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    loss_d  = loss_q;

    // Abort outranks any progress once the sequence has started.
    if (state_q != WAIT_LOCK && abort) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      stage_d = '0;
      rst_d   = '1;
      ready_d = 1'b0;
      if (!lock_s) begin
        loss_d = sat_inc(loss_q);
      end
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (lock_s && !req_s) begin
            state_d = STABLE;
            cnt_d   = '0;
          end
        end
        STABLE: begin
          if (cnt_q == LOCK_LAST) begin
            // Shifting in zeros from bit 0 keeps releases strictly ordered.
            rst_d   = rst_q << 1;
            cnt_d   = '0;
            stage_d = 4'd1;
            if (NUM_STAGES == 1) begin
              ready_d = 1'b1;
              state_d = RUN;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            rst_d   = rst_q << 1;
            cnt_d   = '0;
            stage_d = stage_q + 4'd1;
            if (stage_q == STAGE_LAST) begin
              ready_d = 1'b1;
              state_d = RUN;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = WAIT_LOCK;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      stage_q <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      loss_q  <= loss_d;
    end
  end

  assign reset_out       = rst_q;
  assign ready           = ready_q;
  assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed timing checks plus a randomized run
// compared every cycle against a run-length reference model.
module tb_pll_reset_sequencer;

  localparam int SS  = 2;
  localparam int LSC = 8;
  localparam int GAP = 4;
  localparam int NS  = 3;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          pll_locked = 1'b0;
  logic          ext_reset_req = 1'b0;
  logic [NS-1:0] reset_out;
  logic          ready;
  logic [7:0]    lock_loss_count;

  int checks = 0;
  int errors = 0;
  logic scb_en = 1'b0;

  always #5 clock = ~clock;

  pll_reset_sequencer #(
    .SYNC_STAGES        (SS),
    .LOCK_STABLE_CYCLES (LSC),
    .STAGE_GAP          (GAP),
    .NUM_STAGES         (NS)
  ) dut (
    .clock           (clock),
    .resetn          (resetn),
    .pll_locked      (pll_locked),
    .ext_reset_req   (ext_reset_req),
    .reset_out       (reset_out),
    .ready           (ready),
    .lock_loss_count (lock_loss_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the sequencer's outputs depend only on how many
  // consecutive edges have seen a good synchronised sample (lock=1, req=0).
  // Stage i is released once that run reaches 1+LSC+GAP*i.
  logic [SS-1:0] m_lh, m_rh;
  int            m_run;
  int            m_cnt;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_lh  <= '0;
      m_rh  <= '0;
      m_run <= 0;
      m_cnt <= 0;
    end else begin
      if (m_lh[SS-1] && !m_rh[SS-1]) m_run <= (m_run < 100000) ? m_run + 1 : m_run;
      else                           m_run <= 0;
      if (!m_lh[SS-1] && m_run > 0)  m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
      m_lh <= {m_lh[SS-2:0], pll_locked};
      m_rh <= {m_rh[SS-2:0], ext_reset_req};
    end
  end

  function automatic logic [NS-1:0] exp_rst(input int run);
    logic [NS-1:0] r;
    for (int i = 0; i < NS; i++) r[i] = (run >= 1 + LSC + GAP * i) ? 1'b0 : 1'b1;
    return r;
  endfunction

  function automatic logic exp_ready(input int run);
    return (run >= 1 + LSC + GAP * (NS - 1));
  endfunction

  function automatic logic ord_ok(input logic [NS-1:0] r);
    for (int i = 1; i < NS; i++) if (!r[i] && r[i-1]) return 1'b0;
    return 1'b1;
  endfunction

  a_order: assert property (@(posedge clock) ord_ok(reset_out))
    else $error("release ordering violated reset_out=%b", reset_out);

  always @(negedge clock) begin
    if (scb_en) begin
      check_val("sb_reset_out", 32'(reset_out), 32'(exp_rst(m_run)));
      check_val("sb_ready", 32'(ready), 32'(exp_ready(m_run)));
      check_val("sb_loss_cnt", 32'(lock_loss_count), 32'(m_cnt));
      check_val("sb_order", 32'(ord_ok(reset_out)), 32'd1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int ldn;
    int rq;
    int r;
    ldn = 0;
    rq  = 0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_reset_out", 32'(reset_out), 32'h7);
    check_val("rst_ready", 32'(ready), 32'd0);
    check_val("rst_loss_cnt", 32'(lock_loss_count), 32'd0);

    // Test 1: release latency from the first good sample (edge 0)
    #1;
    resetn = 1'b1;
    pll_locked = 1'b1;
    scb_en = 1'b1;
    repeat (10) @(posedge clock); #1;
    check_val("t1_e9", 32'(reset_out), 32'h7);
    @(posedge clock); #1;
    check_val("t1_e10", 32'(reset_out), 32'h6);
    repeat (4) @(posedge clock); #1;
    check_val("t1_e14", 32'(reset_out), 32'h4);
    repeat (4) @(posedge clock); #1;
    check_val("t1_e18", 32'(reset_out), 32'h0);
    check_val("t1_ready", 32'(ready), 32'd1);
    check_val("t1_loss_cnt", 32'(lock_loss_count), 32'd0);

    // Test 2: lock loss in RUN, then relock
    #1;
    repeat (2) @(posedge clock); #2;
    pll_locked = 1'b0;
    repeat (2) @(posedge clock); #1;
    check_val("t2_e1_ready", 32'(ready), 32'd1);
    @(posedge clock); #1;
    check_val("t2_e2_reset_out", 32'(reset_out), 32'h7);
    check_val("t2_e2_ready", 32'(ready), 32'd0);
    check_val("t2_e2_loss_cnt", 32'(lock_loss_count), 32'd1);
    #1;
    pll_locked = 1'b1;
    repeat (10) @(posedge clock); #1;
    check_val("t2_relock_e9", 32'(reset_out), 32'h7);
    @(posedge clock); #1;
    check_val("t2_relock_e10", 32'(reset_out), 32'h6);
    repeat (8) @(posedge clock); #1;
    check_val("t2_relock_e18", 32'(reset_out), 32'h0);
    check_val("t2_relock_ready", 32'(ready), 32'd1);

    // Test 3: one-cycle lock drop during STABLE
    #1;
    pll_locked = 1'b0;
    repeat (4) @(posedge clock); #2;
    pll_locked = 1'b1;
    repeat (6) @(posedge clock); #2;
    pll_locked = 1'b0;
    @(posedge clock); #2;
    pll_locked = 1'b1;
    repeat (10) @(posedge clock); #1;
    check_val("t3_e16", 32'(reset_out), 32'h7);
    check_val("t3_loss_cnt", 32'(lock_loss_count), 32'd3);
    @(posedge clock); #1;
    check_val("t3_e17", 32'(reset_out), 32'h6);

    // Test 4: three-cycle request during RELEASE
    #1;
    ext_reset_req = 1'b1;
    repeat (3) @(posedge clock); #1;
    check_val("t4_abort", 32'(reset_out), 32'h7);
    check_val("t4_loss_cnt", 32'(lock_loss_count), 32'd3);
    #1;
    ext_reset_req = 1'b0;
    repeat (11) @(posedge clock); #1;
    check_val("t4_reseq", 32'(reset_out), 32'h6);
    check_val("t4_loss_cnt2", 32'(lock_loss_count), 32'd3);

    // Randomized drops, requests and glitches (captured and missed)
    #1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock); #2;
      if (ldn > 0) ldn--;
      if (rq > 0) rq--;
      r = int'($urandom_range(0, 199));
      if (r < 3)      ldn = int'($urandom_range(1, 4));
      else if (r < 5) rq  = int'($urandom_range(1, 4));
      pll_locked    = (ldn == 0);
      ext_reset_req = (rq > 0);
      if (r == 5) begin
        #2 pll_locked = ~pll_locked;
        #2 pll_locked = (ldn == 0);
      end else if (r == 6) begin
        #6 pll_locked = ~pll_locked;
      end else if (r == 7) begin
        #2 ext_reset_req = ~ext_reset_req;
        #2 ext_reset_req = (rq > 0);
      end
    end
    @(posedge clock); #2;
    pll_locked = 1'b0;
    ext_reset_req = 1'b0;
    repeat (4) @(posedge clock); #2;

    // Test 5: 300 lock-loss events saturate the counter
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b1;
      repeat (4) @(posedge clock); #2;
      pll_locked = 1'b0;
      repeat (3) @(posedge clock); #2;
    end
    repeat (3) @(posedge clock); #1;
    check_val("t5_saturate", 32'(lock_loss_count), 32'd255);
    #1;

    // Test 6: asynchronous reset mid-RELEASE
    pll_locked = 1'b1;
    repeat (12) @(posedge clock); #1;
    check_val("t6_in_release", 32'(reset_out), 32'h6);
    #2;
    resetn = 1'b0;
    #1;
    check_val("t6_async_reset_out", 32'(reset_out), 32'h7);
    check_val("t6_async_ready", 32'(ready), 32'd0);
    check_val("t6_async_loss_cnt", 32'(lock_loss_count), 32'd0);
    @(posedge clock); #2;
    resetn = 1'b1;
    repeat (40) @(posedge clock); #1;
    check_val("t6_final_ready", 32'(ready), 32'd1);

    scb_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
